// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready on the operand side,
// valid/ready plus registered result and flags on the result side.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [3:0]       Op;
  logic             invA;
  logic             invB;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] Hi;
  logic             Ofl;
  logic             Cout;
  logic             Z;

  modport master (
    output in_valid, A, B, Cin, Op, invA, invB, sign, out_ready,
    input  in_ready, out_valid, Out, Hi, Ofl, Cout, Z
  );

  modport slave (
    input  in_valid, A, B, Cin, Op, invA, invB, sign, out_ready,
    output in_ready, out_valid, Out, Hi, Ofl, Cout, Z
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle shift/rotate/add/logic ops plus an iterative
// shift-add unsigned multiplier, with registered results and flags.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ROL, OP_SLL, OP_ROR, OP_SRL, OP_ADD, OP_OR, OP_XOR, OP_AND
  } op_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               ofl_q, ofl_d;
  logic               cout_q, cout_d;
  logic               z_q, z_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               in_ready;
  logic               accept;
  logic [WIDTH-1:0]   a_inv, b_inv;
  logic [CW-1:0]      shamt;
  logic [CW:0]        rshamt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     step;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ofl, alu_cout;

  // A new op may enter in the same cycle a finished result is consumed.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = bus.out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  // Single-cycle datapath, evaluated straight from the (optionally inverted) inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    alu_res  = '0;
    alu_ofl  = 1'b0;
    alu_cout = 1'b0;
    a_inv    = bus.invA ? ~bus.A : bus.A;
    b_inv    = bus.invB ? ~bus.B : bus.B;
    shamt    = b_inv[CW-1:0];
    rshamt   = (CW+1)'(WIDTH) - {1'b0, shamt};
    sum      = {1'b0, a_inv} + {1'b0, b_inv} + {{WIDTH{1'b0}}, bus.Cin};
    case (op_e'(bus.Op[2:0]))
      OP_ROL:  alu_res = (a_inv << shamt) | (a_inv >> rshamt);
      OP_SLL:  alu_res = a_inv << shamt;
      OP_ROR:  alu_res = (a_inv >> shamt) | (a_inv << rshamt);
      OP_SRL:  alu_res = a_inv >> shamt;
      OP_ADD: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ofl  = bus.sign ? ((a_inv[WIDTH-1] == b_inv[WIDTH-1]) &&
                               (sum[WIDTH-1] != a_inv[WIDTH-1]))
                            : sum[WIDTH];
      end
      OP_OR:   alu_res = a_inv | b_inv;
      OP_XOR:  alu_res = a_inv ^ b_inv;
      OP_AND:  alu_res = a_inv & b_inv;
      default: alu_res = '0;
    endcase
  end

  // Multiplier step: conditionally add the multiplicand into the upper half,
  // then shift the whole product right; the multiplier drains out of the bottom.
  assign step = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    ofl_d   = ofl_q;
    cout_d  = cout_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (bus.Op[3]) begin
            mcand_d = a_inv;
            prod_d  = {{WIDTH{1'b0}}, b_inv};
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            out_d   = alu_res;
            hi_d    = '0;
            ofl_d   = alu_ofl;
            cout_d  = alu_cout;
            z_d     = (alu_res == '0);
            state_d = DONE;
          end
        end else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        prod_d = {step, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          out_d   = prod_d[WIDTH-1:0];
          hi_d    = prod_d[2*WIDTH-1:WIDTH];
          ofl_d   = |prod_d[2*WIDTH-1:WIDTH];
          cout_d  = 1'b0;
          z_d     = (prod_d[WIDTH-1:0] == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      ofl_q   <= 1'b0;
      cout_q  <= 1'b0;
      z_q     <= 1'b1;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      ofl_q   <= ofl_d;
      cout_q  <= cout_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.Out       = out_q;
  assign bus.Hi        = hi_q;
  assign bus.Ofl       = ofl_q;
  assign bus.Cout      = cout_q;
  assign bus.Z         = z_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 16-bit combinational ALU. It keeps the same eight single-cycle operations (shift/rotate, add, or, xor, and), operand inversion and flags. It adds a WIDTH parameter, registered results behind a valid/ready handshake, and an iterative shift-add unsigned multiplier. It sits between the decode/register-read stage and writeback in multi-cycle datapaths, and stalls upstream via `in_ready` while a multiply is in progress.

## Interface
- `WIDTH`, 16: datapath width. Must be a power of two, at least 8. `CW = log2(WIDTH)`.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands and op are presented.
- `in_ready` output 1: block can accept an operation this cycle.
- `A`, `B` input WIDTH: operands.
- `Cin` input 1: adder carry-in (add only).
- `Op` input 4: operation select.
  - `Op[3]=1`: MUL.
  - Otherwise `Op[2:0]`: 000 rotate-left, 001 shift-left-logical, 010 rotate-right, 011 shift-right-logical, 100 add, 101 or, 110 xor, 111 and.
- `invA`, `invB` input 1: bitwise-invert the operand before any operation, including MUL.
- `sign` input 1: add overflow is computed as signed (1) or unsigned (0).
- `out_valid` output 1: result registers hold a valid, unconsumed result.
- `out_ready` input 1: consumer accepts the result.
- `Out` output WIDTH: result; low half of the product for MUL.
- `Hi` output WIDTH: high half of the product for MUL; 0 for all other ops.
- `Ofl`, `Cout`, `Z` output 1: overflow, carry-out, zero flag (`Out == 0`).

## Operation
- Operands `A'`/`B'` are `A`/`B` after optional inversion. They are captured into internal registers on accept; inputs are not sampled after that.
- Accept condition: `in_valid && in_ready`.
- Shift and rotate ops:
  - Shift count is `B'[CW-1:0]`; upper bits are ignored.
  - `Ofl=0`, `Cout=0`.
- Add: `A' + B' + Cin`, modulo 2^WIDTH.
  - `Cout` is the carry out of the MSB.
  - `Ofl`: if `sign=1`, signed overflow (both operands have the same MSB and the result MSB differs); if `sign=0`, equal to `Cout`.
- Logic ops: `Ofl=0`, `Cout=0`.
- MUL: unsigned `A' * B'` producing a 2*WIDTH-bit product, split into `{Hi, Out}`.
  - One shift-add iteration per cycle, WIDTH iterations.
  - `Ofl = (Hi != 0)`, `Cout = 0`. `sign` and `Cin` are ignored.
- State machine:
  - `IDLE`: `in_ready=1`. A single-cycle op is computed and written to the result registers on accept, then go to `DONE`. MUL goes to `BUSY` with iteration count 0.
  - `BUSY`: `in_ready=0`. One iteration per cycle. After iteration WIDTH-1 completes, the result registers are written and the state goes to `DONE`.
  - `DONE`: `out_valid=1`; result and flags are held stable.
    - `out_ready=1` with no accept: go to `IDLE`.
    - `in_ready = out_ready` in this state, so a new op can be accepted in the same cycle the result is consumed; that new op behaves exactly as an accept from `IDLE`.
- `Op` values 1001–1111 are all MUL; `Op[2:0]` is ignored when `Op[3]=1`.

## Timing
- Reset, synchronous, taking priority over everything:
  - State goes to `IDLE`; `out_valid=0`, `in_ready=1`.
  - `Out=0`, `Hi=0`, `Ofl=0`, `Cout=0`, `Z=1`.
  - Iteration counter cleared.
  - Reset during `BUSY` or `DONE` discards the operation or result; no `out_valid` follows.
- Latency from the accept edge to the first cycle with `out_valid=1`:
  - Non-MUL ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Throughput:
  - Non-MUL ops: one per cycle while `out_ready` stays 1.
  - MUL: one per WIDTH+1 cycles.
- `out_valid` and all outputs are registered; there are no combinational paths from inputs to `Out` or the flags.
- `in_ready` depends combinationally only on state and `out_ready`.
- While `out_valid=1` and `out_ready=0`, outputs must not change; `in_valid` is ignored.
- The result is consumed in the cycle where `out_valid && out_ready`.

## Test plan
- Reset: hold `rst` for 2 cycles, then release.
  - During reset and after: `out_valid=0`, `in_ready=1`, `Out=0`, `Hi=0`, `Z=1`.
  - Repeat with `rst` asserted mid-MUL (cycle 5 of BUSY): the block returns to `IDLE` and no `out_valid` appears.
- Add, WIDTH=16: `A=0x7FFF`, `B=0x0001`, `Cin=0`, `sign=1`, Op add.
  - Next cycle: `Out=0x8000`, `Ofl=1`, `Cout=0`, `Z=0`.
  - Same operands with `sign=0`: `Ofl=0`.
- Subtract via inversion: `A=5`, `B=5`, `invB=1`, `Cin=1`, Op add.
  - Response: `Out=0`, `Z=1`, `Cout=1`, `Ofl=0`.
- Shifts and rotates:
  - Rotate-left `A=0x8001`, `B=0x0011` (count 1) gives `0x0003`.
  - Shift-right-logical `A=0x8000`, count 15 gives `0x0001`.
  - Rotate-right `A=0x0001`, count 4 gives `0x1000`.
- MUL: `A=0x1234`, `B=0x0100`.
  - `in_ready=0` for 16 cycles.
  - `out_valid=1` 17 cycles after accept, with `Out=0x3400`, `Hi=0x0012`, `Ofl=1`.
  - `0xFFFF*0xFFFF` gives `Hi=0xFFFE`, `Out=0x0001`.
- Backpressure: hold `out_ready=0` for 5 cycles after an `or` result.
  - Outputs stay stable and a new `in_valid` is not accepted.
  - Then raise `out_ready` with a new add pending: the add is accepted that cycle and its result appears the next cycle.
